nq_backtrack_stack: RTL
=======================

# nq_backtrack_stack

LIFO backtrack store for the N-Queens solver datapath. Holds one 4-field board-state entry (columns, left diagonals, right diagonals, remaining candidates) per placed row. Its registered top-of-stack output feeds the restore input of the 32-bit 2:1 state-select mux, so the solver can backtrack to the parent row's state. Push, pop and replace each complete in one cycle; overflow and underflow are detected explicitly.

## Interface
- `WIDTH`, 32 — bits per field (board size N ≤ WIDTH)
- `DEPTH`, 32 — maximum stored entries (≥ 2)
- `LVLW`, 6 — level counter width; must satisfy 2^LVLW > DEPTH
- `clk`  in  1  — single clock, rising edge
- `rst_n`  in  1  — asynchronous, active-low reset
- `clear`  in  1  — synchronous flush
- `push`  in  1  — push `{in_cols,in_ld,in_rd,in_avail}`
- `pop`  in  1  — discard top entry
- `in_cols`, `in_ld`, `in_rd`, `in_avail`  in  WIDTH each  — entry to push
- `top_cols`, `top_ld`, `top_rd`, `top_avail`  out  WIDTH each  — registered top entry (drives mux restore input)
- `top_valid`  out  1  — stack non-empty
- `full`  out  1  — level == DEPTH
- `level`  out  LVLW  — current entry count
- `ovf_err`, `unf_err`  out  1  — sticky error flags (see Configuration)

## Operation
- Storage: top entry in dedicated registers; entries below it in a DEPTH-1 deep array indexed by level-2.
- Command decode each cycle, priority order:
  - `clear`: level ← 0; top_valid ← 0; top fields ← 0. Error flags also cleared. Other inputs ignored.
  - `push & pop` with level ≥ 1: replace. Top ← inputs; level unchanged; the array is not written.
  - `push & pop` with level == 0: treated as `pop` only (underflow).
  - `push` with level < DEPTH: the current top (if any) moves to array[level-1]; top ← inputs; level+1.
  - `push` with level == DEPTH: ignored; state unchanged; overflow event.
  - `pop` with level ≥ 2: top ← array[level-2]; level−1.
  - `pop` with level == 1: level ← 0; top fields ← 0.
  - `pop` with level == 0: ignored; underflow event.
- `top_valid` = (level != 0); `full` = (level == DEPTH). Both are decoded from the registered level.
- Top fields read 0 whenever level == 0.
- The level counter never wraps: it saturates at 0 and DEPTH through the ignore rules above.

## Timing
- Reset (async assert, sync release): level=0, all top fields=0, top_valid=0, full=0, ovf_err=0, unf_err=0.
- Reset asserted mid-operation discards all entries immediately; array contents are don't-care after reset.
- Latency: a command sampled at edge k is reflected on all outputs after edge k; there are no combinational input→output paths.
- Back-to-back commands are accepted every cycle with no bubbles.

## Configuration
- `NQ_STACK_ERR_EN` defined:
  - `ovf_err` sets on any overflow event and `unf_err` on any underflow event.
  - Both flags are sticky until `clear` or reset.
- Not defined:
  - `ovf_err` and `unf_err` are tied to 0 and no flag registers are built.
  - Illegal commands are still ignored exactly as above.

## Test plan
- Reset, then `push` 0x1/0x2/0x4/0xF → level=1, top_valid=1, top={0x1,0x2,0x4,0xF}; a following `pop` → level=0, top fields all 0.
- Push entries with cols=1..32 (DEPTH=32) → full=1 after the 32nd push. A 33rd push → level stays 32, top_cols=32, ovf_err=1 (macro on) or 0 (macro off). Then 32 pops return top_cols=31,30,…,1,0 in order.
- `pop` at level 0 → level stays 0, unf_err=1 (macro on). A following `clear` → unf_err=0.
- Push A (cols=0x10) then B (cols=0x20), then `push&pop` with C (cols=0x40) → level=2, top_cols=0x40. A following `pop` → top_cols=0x10.
- Push 3 entries, then `clear` together with `push` → level=0, top_valid=0, and the pushed data is not stored.
- Assert `rst_n` low asynchronously mid-sequence at level=5 → level=0 and top_valid=0 before the next clock edge. After release, the first push makes level=1.

Source files
------------

// File: rtl/nq_backtrack_stack_if.sv
// Bus bundle for the N-Queens backtrack stack.
// Handshake: there is no valid/ready pair. clear/push/pop are one-cycle
// commands sampled on every rising clk edge and always accepted. Their
// effect, including on the in_* data, shows on the registered top_* and
// status outputs right after that same edge.
interface nq_backtrack_stack_if #(
  parameter int WIDTH = 32,
  parameter int LVLW  = 6
);
  logic             clear;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] in_cols;
  logic [WIDTH-1:0] in_ld;
  logic [WIDTH-1:0] in_rd;
  logic [WIDTH-1:0] in_avail;
  logic [WIDTH-1:0] top_cols;
  logic [WIDTH-1:0] top_ld;
  logic [WIDTH-1:0] top_rd;
  logic [WIDTH-1:0] top_avail;
  logic             top_valid;
  logic             full;
  logic [LVLW-1:0]  level;
  logic             ovf_err;
  logic             unf_err;

  modport master (
    output clear, push, pop, in_cols, in_ld, in_rd, in_avail,
    input  top_cols, top_ld, top_rd, top_avail, top_valid, full, level,
           ovf_err, unf_err
  );

  modport slave (
    input  clear, push, pop, in_cols, in_ld, in_rd, in_avail,
    output top_cols, top_ld, top_rd, top_avail, top_valid, full, level,
           ovf_err, unf_err
  );
endinterface

// File: rtl/nq_backtrack_stack.sv
// LIFO backtrack store for the N-Queens solver. The top entry lives in
// dedicated registers so the restore mux sees it straight from flops.
// Entries below the top live in a (DEPTH-1)-deep array.
// The optional macro NQ_STACK_ERR_EN builds the sticky overflow and
// underflow flags. Without it, both flags are tied low.
module nq_backtrack_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int LVLW  = 6
) (
  input logic                clk,
  input logic                rst_n,
  nq_backtrack_stack_if.slave bus
);
  typedef struct packed {
    logic [WIDTH-1:0] cols;
    logic [WIDTH-1:0] ld;
    logic [WIDTH-1:0] rd;
    logic [WIDTH-1:0] avail;
  } entry_t;

  localparam int              IDXW    = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
  localparam logic [LVLW-1:0] DEPTH_L = LVLW'(DEPTH);
  localparam logic [LVLW-1:0] ONE     = LVLW'(1);
  localparam logic [LVLW-1:0] TWO     = LVLW'(2);

  entry_t          topEntry;
  entry_t          inEntry;
  entry_t          below [DEPTH-1];
  logic [LVLW-1:0] lvl;
  logic [IDXW-1:0] wrIdx;
  logic [IDXW-1:0] rdIdx;
  logic            doPush;
  logic            doPop;
  logic            doReplace;

  assign inEntry = '{cols: bus.in_cols, ld: bus.in_ld, rd: bus.in_rd, avail: bus.in_avail};
  // The old top goes to slot level-1 when a new entry lands on it.
  assign wrIdx = IDXW'(lvl - ONE);
  // The parent of the top sits at level-2.
  assign rdIdx = IDXW'(lvl - TWO);

  // Command decode in priority order. Illegal commands decode to no action.
  always_comb begin
    doPush    = 1'b0;
    doPop     = 1'b0;
    doReplace = 1'b0;
    if (!bus.clear) begin
      if (bus.push && bus.pop) begin
        doReplace = (lvl != '0);
        doPop     = 1'b0;
      end else if (bus.push) begin
        doPush = (lvl != DEPTH_L);
      end else if (bus.pop) begin
        doPop = (lvl != '0);
      end
    end
  end

  // Level counter and top-of-stack registers. Top reads zero when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl      <= '0;
      topEntry <= '0;
    end else if (bus.clear) begin
      lvl      <= '0;
      topEntry <= '0;
    end else if (doReplace) begin
      topEntry <= inEntry;
    end else if (doPush) begin
      topEntry <= inEntry;
      lvl      <= lvl + ONE;
    end else if (doPop) begin
      lvl      <= lvl - ONE;
      topEntry <= (lvl == ONE) ? entry_t'('0) : below[rdIdx];
    end
  end

  // Spill the current top into the array on a push over a non-empty stack.
  // The contents are meaningless after reset, so the array is not reset.
  always_ff @(posedge clk) begin
    if (doPush && (lvl != '0)) begin
      below[wrIdx] <= topEntry;
    end
  end

  assign bus.top_cols  = topEntry.cols;
  assign bus.top_ld    = topEntry.ld;
  assign bus.top_rd    = topEntry.rd;
  assign bus.top_avail = topEntry.avail;
  assign bus.top_valid = (lvl != '0);
  assign bus.full      = (lvl == DEPTH_L);
  assign bus.level     = lvl;

`ifdef NQ_STACK_ERR_EN
  logic ovfErr;
  logic unfErr;
  logic ovfEvt;
  logic unfEvt;

  // A push at full without pop overflows.
  // A pop at empty underflows, with or without push.
  assign ovfEvt = !bus.clear && bus.push && !bus.pop && (lvl == DEPTH_L);
  assign unfEvt = !bus.clear && bus.pop && (lvl == '0);

  // Sticky error flags, released only by clear or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovfErr <= 1'b0;
      unfErr <= 1'b0;
    end else if (bus.clear) begin
      ovfErr <= 1'b0;
      unfErr <= 1'b0;
    end else begin
      if (ovfEvt) ovfErr <= 1'b1;
      if (unfEvt) unfErr <= 1'b1;
    end
  end

  assign bus.ovf_err = ovfErr;
  assign bus.unf_err = unfErr;
`else
  assign bus.ovf_err = 1'b0;
  assign bus.unf_err = 1'b0;
`endif
endmodule
